led_status_ctrl: RTL and testbench

//  Multi-channel status LED driver for the ECP5 Ethernet board tops; replaces the single hard-coded blink counter.
//  A shared prescaler generates a slow tick; each channel independently runs OFF / ON / BLINK / ACTIVITY mode.

---
 rtl/led_status_ctrl.sv | 174 +++++++++++++++++
 tb/tb_led_status_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_status_ctrl.sv
// Multi-channel status LED driver: a shared prescaler tick drives per-channel
// OFF / ON / BLINK / ACTIVITY behaviour, with every LED output registered.
module led_status_ctrl #(
  parameter int CHANNELS      = 4,
  parameter int CLK_FREQ_HZ   = 25_000_000,
  parameter int TICK_HZ       = 1000,
  parameter int PERIOD_W      = 12,
  parameter int STRETCH_TICKS = 30
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [2*CHANNELS-1:0]        mode_i,
  input  logic [PERIOD_W*CHANNELS-1:0] period_i,
  input  logic [CHANNELS-1:0]          event_i,
  output logic [CHANNELS-1:0]          led_o,
  output logic                         tick_o
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW = $clog2(STRETCH_TICKS + 1);

  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]  PRESC_PRE  = PW'(DIV - 2);
  localparam logic [SCW-1:0] SC_LAST    = SCW'(STRETCH_TICKS - 1);

  localparam logic [1:0] MODE_OFF      = 2'b00;
  localparam logic [1:0] MODE_ON       = 2'b01;
  localparam logic [1:0] MODE_BLINK    = 2'b10;
  localparam logic [1:0] MODE_ACTIVITY = 2'b11;

  typedef enum logic [1:0] {
    ACT_IDLE      = 2'd0,
    ACT_FLASH_ON  = 2'd1,
    ACT_FLASH_OFF = 2'd2
  } act_state_t;

  if (DIV < 2) begin : g_bad_div
    $error("led_status_ctrl: CLK_FREQ_HZ / TICK_HZ must be at least 2");
  end
  if (CHANNELS < 1 || STRETCH_TICKS < 1) begin : g_bad_param
    $error("led_status_ctrl: CHANNELS and STRETCH_TICKS must be at least 1");
  end

  logic [PW-1:0] presc;
  logic          tick_q;

  // tick_q is set one cycle early so it is high exactly while presc == DIV-1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else begin
      presc  <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      tick_q <= (presc == PRESC_PRE);
    end
  end

  assign tick_o = tick_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [1:0]          mode;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] period_last;
    logic [PERIOD_W-1:0] cnt;
    logic                phase;
    act_state_t          act_state;
    logic [SCW-1:0]      sc;
    logic                pending;
    logic                led_q;

    assign mode        = mode_i[2*ch +: 2];
    assign period      = period_i[PERIOD_W*ch +: PERIOD_W];
    // A zero period behaves as one tick per half-period.
    assign period_last = (period == '0) ? '0 : period - PERIOD_W'(1);

    // led_q is loaded with the value matching the next state, so the LED
    // and the channel state always change on the same edge.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt       <= '0;
        phase     <= 1'b1;
        act_state <= ACT_IDLE;
        sc        <= '0;
        pending   <= 1'b0;
        led_q     <= 1'b0;
      end else begin
        case (mode)
          MODE_BLINK: begin
            act_state <= ACT_IDLE;
            sc        <= '0;
            pending   <= 1'b0;
            led_q     <= phase;
            if (tick_q) begin
              if (cnt >= period_last) begin
                cnt   <= '0;
                phase <= ~phase;
                led_q <= ~phase;
              end else begin
                cnt <= cnt + PERIOD_W'(1);
              end
            end
          end
          MODE_ACTIVITY: begin
            cnt   <= '0;
            phase <= 1'b1;
            case (act_state)
              ACT_IDLE: begin
                led_q <= 1'b0;
                if (event_i[ch]) begin
                  act_state <= ACT_FLASH_ON;
                  sc        <= '0;
                  pending   <= 1'b0;
                  led_q     <= 1'b1;
                end
              end
              ACT_FLASH_ON: begin
                led_q <= 1'b1;
                if (event_i[ch]) pending <= 1'b1;
                if (tick_q) begin
                  if (sc == SC_LAST) begin
                    act_state <= ACT_FLASH_OFF;
                    sc        <= '0;
                    led_q     <= 1'b0;
                  end else begin
                    sc <= sc + SCW'(1);
                  end
                end
              end
              ACT_FLASH_OFF: begin
                led_q <= 1'b0;
                if (event_i[ch]) pending <= 1'b1;
                if (tick_q) begin
                  if (sc == SC_LAST) begin
                    sc <= '0;
                    if (pending || event_i[ch]) begin
                      act_state <= ACT_FLASH_ON;
                      pending   <= 1'b0;
                      led_q     <= 1'b1;
                    end else begin
                      act_state <= ACT_IDLE;
                    end
                  end else begin
                    sc <= sc + SCW'(1);
                  end
                end
              end
              default: begin
                act_state <= ACT_IDLE;
                sc        <= '0;
                pending   <= 1'b0;
                led_q     <= 1'b0;
              end
            endcase
          end
          default: begin
            cnt       <= '0;
            phase     <= 1'b1;
            act_state <= ACT_IDLE;
            sc        <= '0;
            pending   <= 1'b0;
            led_q     <= (mode == MODE_ON);
          end
        endcase
      end
    end

    assign led_o[ch] = led_q;
  end

  // MODE_OFF is covered by the default branch above.
  localparam logic [1:0] MODE_OFF_UNUSED = MODE_OFF;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with hand-computed expectations
// (DIV=10, STRETCH_TICKS=3, 4 channels, 4-bit periods).
module tb_led_status_ctrl;

  localparam int CH = 4;
  localparam int PW = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [2*CH-1:0] mode_i;
  logic [PW*CH-1:0] period_i;
  logic [CH-1:0]   event_i;
  logic [CH-1:0]   led_o;
  logic            tick_o;

  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  led_status_ctrl #(
    .CHANNELS(CH), .CLK_FREQ_HZ(1000), .TICK_HZ(100),
    .PERIOD_W(PW), .STRETCH_TICKS(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .period_i(period_i),
    .event_i(event_i), .led_o(led_o), .tick_o(tick_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (tick_o !== 1'b1 && n < 25) begin
      step();
      n++;
    end
    if (tick_o !== 1'b1) check("tick_timeout", {31'd0, tick_o}, 32'd1);
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode_i[2*ch +: 2] = m;
  endtask

  task automatic set_period(input int ch, input logic [PW-1:0] p);
    period_i[PW*ch +: PW] = p;
  endtask

  task automatic pulse_event(input int ch);
    event_i[ch] = 1'b1;
    step();
    event_i[ch] = 1'b0;
  endtask

  // scoreboard: one expected LED value per tick, sampled the cycle after it
  task automatic run_ticks(input int ch, input string tag);
    logic [0:0] e;
    while (exp_q.size() > 0) begin
      wait_tick();
      step();
      e = exp_q.pop_front();
      check(tag, {31'd0, led_o[ch]}, {31'd0, e});
    end
  endtask

  initial begin
    rst_i    = 1'b1;
    mode_i   = '0;
    period_i = '0;
    event_i  = '0;
    repeat (3) step();
    check("rst_led", {28'd0, led_o}, 32'd0);
    check("rst_tick", {31'd0, tick_o}, 32'd0);

    // cycle 1 is the first cycle with rst_i low
    rst_i = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      check($sformatf("tick_c%0d", c), {31'd0, tick_o}, {31'd0, (c % 10 == 0)});
      step();
    end
    repeat (3) step();
    rst_i = 1'b1;
    step();
    check("midrst_tick", {31'd0, tick_o}, 32'd0);
    rst_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("midrst_c%0d", c), {31'd0, tick_o}, {31'd0, (c == 10)});
      step();
    end

    // static modes
    set_mode(0, 2'b01);
    set_mode(1, 2'b00);
    #1;
    check("on_latency", {31'd0, led_o[0]}, 32'd0);
    step();
    check("on_ch0", {31'd0, led_o[0]}, 32'd1);
    check("off_ch1", {31'd0, led_o[1]}, 32'd0);
    set_mode(0, 2'b00);
    step();
    check("off_ch0", {31'd0, led_o[0]}, 32'd0);
    set_mode(0, 2'b01);

    // BLINK period 2
    set_period(2, 4'd2);
    wait_tick();
    step();
    set_mode(2, 2'b10);
    step();
    check("blink_entry", {31'd0, led_o[2]}, 32'd1);
    exp_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    run_ticks(2, "blink_p2");

    // BLINK period 0 toggles every tick
    set_mode(2, 2'b00);
    step();
    set_period(2, 4'd0);
    wait_tick();
    step();
    set_mode(2, 2'b10);
    step();
    check("blink0_entry", {31'd0, led_o[2]}, 32'd1);
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    run_ticks(2, "blink_p0");

    // BLINK period change 5 -> 1 mid-count
    set_mode(2, 2'b00);
    step();
    set_period(2, 4'd5);
    wait_tick();
    step();
    set_mode(2, 2'b10);
    step();
    exp_q = '{1'b1, 1'b1};
    run_ticks(2, "blink_p5");
    set_period(2, 4'd1);
    exp_q = '{1'b0, 1'b1, 1'b0};
    run_ticks(2, "blink_p5to1");
    set_mode(2, 2'b00);

    // ACTIVITY single event
    set_mode(3, 2'b11);
    wait_tick();
    step();
    check("act_idle", {31'd0, led_o[3]}, 32'd0);
    pulse_event(3);
    check("act_start", {31'd0, led_o[3]}, 32'd1);
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_ticks(3, "act_single");

    // ACTIVITY coalescing: four extra events give one extra flash
    wait_tick();
    step();
    pulse_event(3);
    repeat (4) begin
      step();
      pulse_event(3);
    end
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_ticks(3, "act_coalesce");

    // event in the final FLASH_OFF tick cycle
    wait_tick();
    step();
    pulse_event(3);
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    run_ticks(3, "act_late_pre");
    wait_tick();
    pulse_event(3);
    check("act_late_event", {31'd0, led_o[3]}, 32'd1);
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_ticks(3, "act_late_post");

    // mode exit with pending set
    wait_tick();
    step();
    pulse_event(3);
    step();
    pulse_event(3);
    check("exit_pre", {31'd0, led_o[3]}, 32'd1);
    set_mode(3, 2'b00);
    step();
    check("exit_off", {31'd0, led_o[3]}, 32'd0);
    set_mode(3, 2'b11);
    step();
    check("exit_return", {31'd0, led_o[3]}, 32'd0);
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_ticks(3, "exit_idle");
    pulse_event(3);
    check("exit_new_event", {31'd0, led_o[3]}, 32'd1);
    check("ch0_hold", {31'd0, led_o[0]}, 32'd1);

    // reset mid-operation
    set_mode(2, 2'b10);
    rst_i = 1'b1;
    step();
    check("rst_mid_led", {28'd0, led_o}, 32'd0);
    check("rst_mid_tick", {31'd0, tick_o}, 32'd0);
    rst_i = 1'b0;
    step();
    check("rst_mid_on", {31'd0, led_o[0]}, 32'd1);
    check("rst_mid_blink", {31'd0, led_o[2]}, 32'd1);
    check("rst_mid_act", {31'd0, led_o[3]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
